// File: rtl/laser_pulse_capture.sv
// Captures the first laser pulse of each frame from a 10-sub-sample-per-clock word stream
// and reports its rise position, width and error flags one cycle after the frame closes.
module laser_pulse_capture #(
  parameter int unsigned TIMEOUT_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  laser_data_in,
  input  logic        frame_start,
  input  logic [1:0]  frame_type,
  input  logic [31:0] expected_width,
  input  logic [7:0]  tolerance,
  output logic        meas_valid,
  output logic [1:0]  meas_frame_type,
  output logic [31:0] rise_pos,
  output logic [31:0] pulse_width,
  output logic        pulse_seen,
  output logic        width_err,
  output logic        multi_err,
  output logic        trunc_err,
  output logic        bg_err,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RISE = 2'd1, IN_PULSE = 2'd2, POST = 2'd3} state_t;

  localparam logic [31:0] LAST_IDX = 32'(TIMEOUT_WORDS - 1);

  state_t      state;
  logic        prev_bit;
  logic [31:0] word_idx;
  logic [31:0] rise_r;
  logic [31:0] width_r;
  logic        seen_r;
  logic        multi_r;
  logic [1:0]  type_r;
  logic [31:0] exp_r;
  logic [7:0]  tol_r;

  logic        active;
  logic [31:0] cur_idx;
  logic [31:0] base;
  logic [9:0]  prev_vec;
  logic [9:0]  rises;
  logic [9:0]  falls;
  state_t      s_in;
  logic [31:0] rise_in;
  logic [31:0] width_in;
  logic        seen_in;
  logic        multi_in;

  assign dbg_state = state;
  assign active    = frame_start || (state != IDLE);
  assign cur_idx   = frame_start ? 32'd0 : ((&word_idx) ? word_idx : word_idx + 32'd1);
  assign base      = (cur_idx << 3) + (cur_idx << 1);
  // The sub-sample before bit 0 is bit 9 of the previous word, except at a frame boundary.
  assign prev_vec  = {laser_data_in[8:0], frame_start ? 1'b0 : prev_bit};
  assign rises     = laser_data_in & ~prev_vec;
  assign falls     = ~laser_data_in & prev_vec;
  assign s_in      = frame_start ? WAIT_RISE : state;
  assign rise_in   = frame_start ? 32'd0 : rise_r;
  assign width_in  = frame_start ? 32'd0 : width_r;
  assign seen_in   = frame_start ? 1'b0 : seen_r;
  assign multi_in  = frame_start ? 1'b0 : multi_r;

  logic       hr, hf;
  logic [3:0] fr, ff;

  // First rise in the word, and the first fall that ends the pulse (after that rise when
  // the pulse also starts in this word).
  always_comb begin
    hr = 1'b0;
    fr = 4'd0;
    hf = 1'b0;
    ff = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!hr && rises[i]) begin
        hr = 1'b1;
        fr = 4'(i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (!hf && falls[i] && (s_in != WAIT_RISE || (hr && 4'(i) > fr))) begin
        hf = 1'b1;
        ff = 4'(i);
      end
    end
  end

  state_t      n_state;
  logic [31:0] n_rise;
  logic [31:0] n_width;
  logic        n_seen;
  logic        n_multi;

  always_comb begin
    n_state = s_in;
    n_rise  = rise_in;
    n_width = width_in;
    n_seen  = seen_in;
    n_multi = multi_in;
    case (s_in)
      WAIT_RISE: begin
        if (hr) begin
          n_seen  = 1'b1;
          n_rise  = base + 32'(fr);
          n_multi = multi_in | (|(rises & (rises - 10'd1)));
          if (hf) begin
            n_width = 32'(ff) - 32'(fr);
            n_state = POST;
          end else begin
            n_state = IN_PULSE;
          end
        end
      end
      IN_PULSE: begin
        // Any rise seen here must follow the fall in this word, so it is a second pulse.
        n_multi = multi_in | (|rises);
        if (hf) begin
          n_width = base + 32'(ff) - rise_in;
          n_state = POST;
        end
      end
      POST:    n_multi = multi_in | (|rises);
      default: ;
    endcase
  end

  logic        close_fs;
  logic        timeout_hit;
  logic        close;
  state_t      c_state;
  logic [31:0] c_rise;
  logic [31:0] c_width;
  logic        c_seen;
  logic        c_multi;
  logic [31:0] c_last_p1;
  logic [31:0] close_pos;
  logic        c_trunc;
  logic [31:0] c_w;
  logic [31:0] diff;
  logic        is_bg;
  logic        c_werr;

  // A frame_start close reports the old frame as it stood; a timeout close includes this word.
  assign close_fs    = frame_start && (state != IDLE);
  assign timeout_hit = !frame_start && (state != IDLE) && (cur_idx == LAST_IDX);
  assign close       = close_fs || timeout_hit;
  assign c_state     = close_fs ? state   : n_state;
  assign c_rise      = close_fs ? rise_r  : n_rise;
  assign c_width     = close_fs ? width_r : n_width;
  assign c_seen      = close_fs ? seen_r  : n_seen;
  assign c_multi     = close_fs ? multi_r : n_multi;
  assign c_last_p1   = (close_fs ? word_idx : cur_idx) + 32'd1;
  assign close_pos   = (c_last_p1 << 3) + (c_last_p1 << 1);
  assign c_trunc     = (c_state == IN_PULSE);
  assign c_w         = c_trunc ? close_pos - c_rise : c_width;
  assign diff        = (c_w >= exp_r) ? c_w - exp_r : exp_r - c_w;
  assign is_bg       = (type_r == 2'b00);
  assign c_werr      = is_bg ? 1'b0 : (c_seen ? (diff > {24'd0, tol_r}) : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      prev_bit        <= 1'b0;
      word_idx        <= 32'd0;
      rise_r          <= 32'd0;
      width_r         <= 32'd0;
      seen_r          <= 1'b0;
      multi_r         <= 1'b0;
      type_r          <= 2'b00;
      exp_r           <= 32'd0;
      tol_r           <= 8'd0;
      meas_valid      <= 1'b0;
      meas_frame_type <= 2'b00;
      rise_pos        <= 32'd0;
      pulse_width     <= 32'd0;
      pulse_seen      <= 1'b0;
      width_err       <= 1'b0;
      multi_err       <= 1'b0;
      trunc_err       <= 1'b0;
      bg_err          <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      meas_valid <= close;
      if (close) begin
        meas_frame_type <= type_r;
        rise_pos        <= c_rise;
        pulse_width     <= c_w;
        pulse_seen      <= c_seen;
        width_err       <= c_werr;
        multi_err       <= c_multi;
        trunc_err       <= c_trunc;
        bg_err          <= is_bg & c_seen;
        timeout         <= timeout_hit;
      end
      if (frame_start) begin
        type_r <= frame_type;
        exp_r  <= expected_width;
        tol_r  <= tolerance;
      end
      if (active) begin
        prev_bit <= laser_data_in[9];
        word_idx <= cur_idx;
        rise_r   <= n_rise;
        width_r  <= n_width;
        seen_r   <= n_seen;
        multi_r  <= n_multi;
        state    <= timeout_hit ? IDLE : n_state;
      end
    end
  end

endmodule

// File: tb/tb_laser_pulse_capture.sv
// Bench for laser_pulse_capture: two instances (timeouts 16 and 4) share one stimulus
// stream and are checked every cycle against a sub-sample-level frame model.
module tb_laser_pulse_capture;

  localparam int TW0 = 16;
  localparam int TW1 = 4;

  logic        clk;
  logic        rst_n;
  logic [9:0]  laser_data_in;
  logic        frame_start;
  logic [1:0]  frame_type;
  logic [31:0] expected_width;
  logic [7:0]  tolerance;

  logic        mv   [2];
  logic [1:0]  mft  [2];
  logic [31:0] mrp  [2];
  logic [31:0] mpw  [2];
  logic        ps   [2];
  logic        we   [2];
  logic        me   [2];
  logic        te   [2];
  logic        be   [2];
  logic        tmo  [2];
  logic [1:0]  dbg  [2];

  laser_pulse_capture #(.TIMEOUT_WORDS(TW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .laser_data_in(laser_data_in), .frame_start(frame_start),
    .frame_type(frame_type), .expected_width(expected_width), .tolerance(tolerance),
    .meas_valid(mv[0]), .meas_frame_type(mft[0]), .rise_pos(mrp[0]), .pulse_width(mpw[0]),
    .pulse_seen(ps[0]), .width_err(we[0]), .multi_err(me[0]), .trunc_err(te[0]),
    .bg_err(be[0]), .timeout(tmo[0]), .dbg_state(dbg[0])
  );

  laser_pulse_capture #(.TIMEOUT_WORDS(TW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .laser_data_in(laser_data_in), .frame_start(frame_start),
    .frame_type(frame_type), .expected_width(expected_width), .tolerance(tolerance),
    .meas_valid(mv[1]), .meas_frame_type(mft[1]), .rise_pos(mrp[1]), .pulse_width(mpw[1]),
    .pulse_seen(ps[1]), .width_err(we[1]), .multi_err(me[1]), .trunc_err(te[1]),
    .bg_err(be[1]), .timeout(tmo[1]), .dbg_state(dbg[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Result layout: type[71:70] rise[69:38] width[37:6] seen werr merr trunc bgerr timeout
  logic [72:0] exp_q[$];
  logic [71:0] last_res [2];
  int          tw       [2];
  bit          in_frame [2];
  logic [9:0]  fw       [2][16];
  int          fn       [2];
  logic [1:0]  m_type   [2];
  logic [31:0] m_ew     [2];
  logic [7:0]  m_tl     [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [71:0] obs(input int i);
    return {mft[i], mrp[i], mpw[i], ps[i], we[i], me[i], te[i], be[i], tmo[i]};
  endfunction

  task automatic cmp_res(input int i, input logic [71:0] o, input logic [71:0] e);
    check($sformatf("d%0d.frame_type", i), 64'(o[71:70]), 64'(e[71:70]));
    check($sformatf("d%0d.rise_pos", i),   64'(o[69:38]), 64'(e[69:38]));
    check($sformatf("d%0d.pulse_width", i), 64'(o[37:6]), 64'(e[37:6]));
    check($sformatf("d%0d.pulse_seen", i), 64'(o[5]), 64'(e[5]));
    check($sformatf("d%0d.width_err", i),  64'(o[4]), 64'(e[4]));
    check($sformatf("d%0d.multi_err", i),  64'(o[3]), 64'(e[3]));
    check($sformatf("d%0d.trunc_err", i),  64'(o[2]), 64'(e[2]));
    check($sformatf("d%0d.bg_err", i),     64'(o[1]), 64'(e[1]));
    check($sformatf("d%0d.timeout", i),    64'(o[0]), 64'(e[0]));
  endtask

  // Reference: walk the frame as one flat sub-sample sequence starting from a 0 sample.
  function automatic logic [71:0] model_close(input int i, input bit to);
    int     n, rise, fall, nr;
    bit     prev, b, seen, trunc, werr, bge;
    longint w, d;
    logic [9:0] wd;
    n = fn[i] * 10;
    prev = 1'b0; rise = -1; fall = -1; nr = 0;
    for (int k = 0; k < n; k++) begin
      wd = fw[i][k / 10];
      b  = wd[k % 10];
      if (!prev && b) begin
        nr++;
        if (rise < 0) rise = k;
      end
      if (prev && !b && rise >= 0 && fall < 0) fall = k;
      prev = b;
    end
    seen  = (rise >= 0);
    trunc = seen && (fall < 0);
    w     = !seen ? 0 : (trunc ? longint'(n - rise) : longint'(fall - rise));
    d     = w - longint'(m_ew[i]);
    if (d < 0) d = -d;
    bge   = (m_type[i] == 2'b00) && seen;
    werr  = (m_type[i] == 2'b00) ? 1'b0 : (!seen ? 1'b1 : (d > longint'(m_tl[i])));
    return {m_type[i], seen ? 32'(rise) : 32'd0, 32'(w), seen, werr, nr > 1, trunc, bge, to};
  endfunction

  // driver: present one word, update the model, then check both instances after the edge
  task automatic step(input logic [9:0] d, input logic fs, input logic [1:0] ft,
                      input logic [31:0] ew, input logic [7:0] tl);
    logic [72:0] ent;
    logic        want;
    laser_data_in  = d;
    frame_start    = fs;
    frame_type     = ft;
    expected_width = ew;
    tolerance      = tl;
    for (int i = 0; i < 2; i++) begin
      if (fs) begin
        if (in_frame[i]) exp_q.push_back({1'(i), model_close(i, 1'b0)});
        in_frame[i] = 1'b1;
        m_type[i] = ft; m_ew[i] = ew; m_tl[i] = tl;
        fw[i][0] = d;
        fn[i] = 1;
      end else if (in_frame[i]) begin
        fw[i][fn[i]] = d;
        fn[i]++;
      end
      if (in_frame[i] && fn[i] == tw[i]) begin
        exp_q.push_back({1'(i), model_close(i, 1'b1)});
        in_frame[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      want = (exp_q.size() > 0) && (exp_q[0][72] == 1'(i));
      check($sformatf("d%0d.meas_valid", i), 64'(mv[i]), 64'(want));
      if (want) begin
        ent = exp_q.pop_front();
        last_res[i] = ent[71:0];
      end
      cmp_res(i, obs(i), last_res[i]);
    end
  endtask

  task automatic word(input logic [9:0] d);
    step(d, 1'b0, 2'b00, 32'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    laser_data_in = 10'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d.rst_valid", i), 64'(mv[i]), 64'd0);
      check($sformatf("d%0d.rst_state", i), 64'(dbg[i]), 64'd0);
      cmp_res(i, obs(i), 72'd0);
      in_frame[i] = 1'b0;
      last_res[i] = 72'd0;
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] rand_word();
    logic [9:0] ones;
    ones = '1;
    case ($urandom_range(0, 4))
      0:       return 10'd0;
      1:       return ones;
      2:       return 10'($urandom);
      3:       return ones << $urandom_range(0, 9);
      default: return ones >> $urandom_range(0, 9);
    endcase
  endfunction

  initial begin
    logic [1:0]  ft;
    logic [31:0] ew;
    logic [7:0]  tl;
    int          len;
    tw[0] = TW0;
    tw[1] = TW1;
    frame_type = 2'b00;
    expected_width = 32'd0;
    tolerance = 8'd0;
    do_reset();

    // frame A: one long pulse from sub-sample 0 to 25
    step(10'h3FF, 1'b1, 2'b01, 32'd25, 8'd0);
    word(10'h3FF); word(10'h01F); word(10'h000);
    // frame B opens and closes frame A
    step(10'h3F0, 1'b1, 2'b10, 32'd9, 8'd0);
    check("a.rise", 64'(mrp[0]), 64'd0);
    check("a.width", 64'(mpw[0]), 64'd25);
    check("a.seen", 64'(ps[0]), 64'd1);
    check("a.errs", 64'({we[0], me[0], te[0], be[0], tmo[0]}), 64'd0);
    word(10'h007); word(10'h000);
    // same-word pulse in word 2
    step(10'h000, 1'b1, 2'b01, 32'd5, 8'd0);
    check("b.rise", 64'(mrp[0]), 64'd4);
    check("b.width", 64'(mpw[0]), 64'd9);
    check("b.frame_type", 64'(mft[0]), 64'd2);
    word(10'h000); word(10'h0F0);
    // two pulses in one word
    step(10'h101, 1'b1, 2'b01, 32'd1, 8'd0);
    check("c.rise", 64'(mrp[0]), 64'd24);
    check("c.width", 64'(mpw[0]), 64'd4);
    check("c.width_err", 64'(we[0]), 64'd1);
    // background frame with a pulse
    step(10'h001, 1'b1, 2'b00, 32'd0, 8'd0);
    check("d.multi", 64'(me[0]), 64'd1);
    check("d.rise", 64'(mrp[0]), 64'd0);
    check("d.width", 64'(mpw[0]), 64'd1);
    word(10'h000);
    // truncated pulse; the 4-word instance times out on the fourth word
    step(10'h3E0, 1'b1, 2'b01, 32'd35, 8'd0);
    check("e.bg_err", 64'(be[0]), 64'd1);
    check("e.width_err", 64'(we[0]), 64'd0);
    word(10'h3FF); word(10'h3FF); word(10'h3FF);
    check("t.valid", 64'(mv[1]), 64'd1);
    check("t.timeout", 64'(tmo[1]), 64'd1);
    check("t.trunc", 64'(te[1]), 64'd1);
    check("t.rise", 64'(mrp[1]), 64'd5);
    check("t.width", 64'(mpw[1]), 64'd35);
    for (int k = 0; k < 14; k++) word(10'h000);
    // reset while inside a pulse discards the frame
    step(10'h3FF, 1'b1, 2'b01, 32'd0, 8'd0);
    word(10'h3FF);
    do_reset();
    word(10'h3FF);
    step(10'h001, 1'b1, 2'b01, 32'd1, 8'd0);
    word(10'h000);
    step(10'h000, 1'b1, 2'b01, 32'd0, 8'd0);
    check("r.rise", 64'(mrp[0]), 64'd0);
    check("r.width", 64'(mpw[0]), 64'd1);

    // randomized frames of 1..20 words, occasional mid-frame reset
    for (int f = 0; f < 300; f++) begin
      ft  = 2'($urandom_range(0, 3));
      ew  = 32'($urandom_range(0, 40));
      tl  = 8'($urandom_range(0, 6));
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        step(rand_word(), k == 0, ft, ew, tl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
